ram_bist: RTL
=============

# ram_bist

Built-in self-test engine that acts as the initiator on the single-port 1024x8 RAM interface (addr/data_in/data_out/wr/cs). On a start pulse it fills every location with the pattern `(2*addr + PAT_OFFSET) mod 2^DW`. It then reads every location back, compares each word with the expected value, and reports pass/fail, the error count and the first failing location. It sits between the system controller and the RAM, and drives the RAM pins directly during a test.

## Interface
- AW, 10, address width; the RAM depth is 2^AW.
- DW, 8, data width.
- PAT_OFFSET, 0, constant added to 2*addr before truncation to DW bits.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a test; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  result of the last completed test; holds until the next start is accepted.
- err_count  out  AW+1  number of miscompares in the last test, range 0..2^AW.
- first_err_addr  out  AW  address of the first miscompare; 0 if there is none.
- first_err_data  out  DW  data read at first_err_addr; 0 if there is none.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data (RAM data_in).
- mem_wr  out  1  1 = write, 0 = read; qualified by mem_cs.
- mem_cs  out  1  RAM chip select, active-high.
- mem_rdata  in  DW  RAM read data (RAM data_out). It is valid one clock after a read is issued (cs=1, wr=0).

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - mem_cs=0, busy=0.
  - start=1 moves the FSM to WRITE and clears err_count, first_err_* and pass in the same edge.
- WRITE:
  - Drives one write per cycle: mem_cs=1, mem_wr=1, mem_addr=a, mem_wdata=pattern(a), for a = 0 .. 2^AW-1.
  - After the write to the last address, the address counter wraps to 0 and the FSM enters READ.
- READ:
  - Drives one read per cycle: mem_cs=1, mem_wr=0, mem_addr=a, mem_wdata=0, for a = 0 .. 2^AW-1.
  - The issued address is delayed one stage, together with a valid bit. mem_rdata is compared in the cycle after each read.
  - After the read of the last address, the FSM enters DRAIN.
- DRAIN:
  - mem_cs=0.
  - Performs the compare for the last address, then enters DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - pass is set to (err_count==0) on entry to DONE.
  - The FSM then returns to IDLE.
- Compare rules:
  - A miscompare (mem_rdata != pattern(delayed addr)) increments err_count.
  - On the first miscompare only, first_err_addr and first_err_data are captured.
  - err_count cannot overflow: its maximum value, 2^AW, fits in AW+1 bits.
- Pattern arithmetic: computed at AW+1 bits, then truncated to DW bits. With DW=8 and PAT_OFFSET=0: addr 127 -> 254, addr 128 -> 0, addr 200 -> 144, addr 1023 -> 254.
- start while busy (WRITE/READ/DRAIN/DONE) is ignored and has no side effect.
- start in the same cycle as rst: rst wins.
- rst in any state, including mid-WRITE or mid-READ:
  - Next state is IDLE.
  - All outputs return to their reset values.
  - The compare pipeline valid bit is cleared, so no stale compare executes.
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_data=0, mem_addr=0, mem_wdata=0, mem_wr=0, mem_cs=0.
- All outputs are registered.

## Timing
- Edge E0 samples start=1. The first write (addr 0) is driven in the cycle after E0.
- The write phase lasts 2^AW cycles and the read phase lasts 2^AW cycles, back to back with no idle cycle.
- The DRAIN phase lasts 1 cycle, then done pulses for 1 cycle.
- done is high in the cycle starting at edge E0 + 2*2^AW + 1; for AW=10 that is 2049 cycles after the start edge.
- Results (pass, err_count, first_err_*) are valid when done=1 and stay stable until the next accepted start.
- mem_cs is never high in IDLE, DRAIN or DONE.
- mem_wr is never high in READ.

## Test plan
- Ideal RAM model (1024x8, 1-cycle read), one start pulse:
  - done after 2049 cycles, pass=1, err_count=0.
  - Data written at addr 200 is 144; at addr 1023 it is 254.
- RAM model with bit 0 stuck at 1: every even pattern word fails, so err_count=1024, pass=0, first_err_addr=0, first_err_data=0x01.
- Single corrupted word at addr 1023 (the last address, which exercises DRAIN): err_count=1, first_err_addr=1023, pass=0.
- start pulsed again at cycle 500 of a test: ignored; done still occurs at the original cycle and results are unchanged.
- rst asserted mid-READ:
  - Next cycle busy=0, mem_cs=0, err_count=0, and done does not pulse.
  - A new start then completes normally with pass=1.
- Two back-to-back tests, the first failing and the second clean: err_count, first_err_* and pass are cleared on the second start, and the second test ends with pass=1.

Source files
------------

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - march-style fill/readback BIST initiator for a single-port RAM
module ram_bist #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int PAT_OFFSET = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW:0]   o_err_count,
  output logic [AW-1:0] o_first_err_addr,
  output logic [DW-1:0] o_first_err_data,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_wr,
  output logic          o_mem_cs,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW:0]   L_PAT_OFFSET = (AW+1)'(PAT_OFFSET);
  localparam logic [AW-1:0] L_ADDR_ONE   = AW'(1);
  localparam logic [AW:0]   L_CNT_ONE    = (AW+1)'(1);

  // Pattern is formed at AW+1 bits so 2*addr never loses its top bit before truncation.
  function automatic logic [DW-1:0] f_pattern(input logic [AW-1:0] a);
    logic [AW:0] v;
    v = {a, 1'b0} + L_PAT_OFFSET;
    return DW'(v);
  endfunction

  logic [2:0]    r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [AW:0]   r_err_count;
  logic [AW-1:0] r_first_err_addr;
  logic [DW-1:0] r_first_err_data;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_wr;
  logic          r_mem_cs;
  logic          r_cmp_valid;
  logic [AW-1:0] r_cmp_addr;

  logic          w_miss;
  logic          w_last_addr;
  logic [AW-1:0] w_next_addr;
  logic [AW:0]   w_err_count_next;

  always_comb begin
    w_miss           = r_cmp_valid && (i_mem_rdata != f_pattern(r_cmp_addr));
    w_err_count_next = w_miss ? (r_err_count + L_CNT_ONE) : r_err_count;
    w_last_addr      = (r_mem_addr == '1);
    w_next_addr      = r_mem_addr + L_ADDR_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_mem_wr         <= 1'b0;
      r_mem_cs         <= 1'b0;
      r_cmp_valid      <= 1'b0;
      r_cmp_addr       <= '0;
    end else begin
      r_done <= 1'b0;

      // Compare stage: the read issued last cycle returns its data now.
      r_cmp_valid <= (r_state == S_READ);
      r_cmp_addr  <= r_mem_addr;
      if (r_cmp_valid) begin
        r_err_count <= w_err_count_next;
        if (w_miss && (r_err_count == '0)) begin
          r_first_err_addr <= r_cmp_addr;
          r_first_err_data <= i_mem_rdata;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state          <= S_WRITE;
            r_busy           <= 1'b1;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
            r_mem_cs         <= 1'b1;
            r_mem_wr         <= 1'b1;
            r_mem_addr       <= '0;
            r_mem_wdata      <= f_pattern('0);
          end
        end
        S_WRITE: begin
          if (w_last_addr) begin
            r_state     <= S_READ;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else begin
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= f_pattern(w_next_addr);
          end
        end
        S_READ: begin
          if (w_last_addr) begin
            r_state    <= S_DRAIN;
            r_mem_cs   <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_mem_addr <= w_next_addr;
          end
        end
        S_DRAIN: begin
          // Last compare lands this edge, so pass must see the updated count.
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_err_count_next == '0);
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_mem_cs <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
  assign o_first_err_data = r_first_err_data;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_wr         = r_mem_wr;
  assign o_mem_cs         = r_mem_cs;

endmodule
